// File: rtl/whack_game_ctrl.sv
// whack_game_ctrl: whack-a-mole sequencer feeding the frame drawer's state input.
// Synchronises the keys, picks moles with an LFSR, times each mole and keeps
// score / miss / round counters for the current game.
module whack_game_ctrl #(
    parameter int unsigned MOLE_TICKS = 25_000_000,
    parameter int unsigned GAP_TICKS  = 12_500_000,
    parameter int unsigned GAME_MOLES = 20,
    parameter int unsigned MAX_MISSES = 3,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic       iStart,
    input  logic [3:0] iHit,
    output logic [2:0] oState,
    output logic       oStateChg,
    output logic [7:0] oScore,
    output logic [1:0] oMisses,
    output logic [4:0] oRound
);

    localparam int unsigned KEY_W    = 5;
    localparam int unsigned TICK_MAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
    localparam int unsigned TIMER_W  = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_TICKS - 1);
    localparam logic [TIMER_W-1:0] MOLE_LAST = TIMER_W'(MOLE_TICKS - 1);

    // Encoding is shared with the frame drawer and must not change.
    typedef enum logic [2:0] {
        ST_START = 3'b000,
        ST_GAME  = 3'b001,
        ST_MOLE1 = 3'b010,
        ST_MOLE2 = 3'b011,
        ST_MOLE3 = 3'b100,
        ST_MOLE4 = 3'b101,
        ST_OVER  = 3'b110
    } state_t;

    state_t               state;
    state_t               state_nxt;
    state_t               mole_sel;
    logic                 state_chg;

    logic [KEY_W-1:0]     key_s1;
    logic [KEY_W-1:0]     key_s2;
    logic [KEY_W-1:0]     key_d;
    logic [KEY_W-1:0]     key_rise;
    logic                 start_rise;
    logic [3:0]           hit_rise;

    logic [7:0]           lfsr;
    logic [TIMER_W-1:0]   timer;
    logic [7:0]           score;
    logic [1:0]           misses;
    logic [4:0]           round;

    logic [3:0]           hole_mask;
    logic                 in_mole;
    logic                 hit_correct;
    logic                 hit_wrong;
    logic                 mole_timeout;
    logic [1:0]           miss_upd;
    logic                 round_end;
    logic                 miss_end;

    logic                 clr_cnt;
    logic                 score_inc;
    logic                 miss_inc;
    logic                 round_inc;
    logic                 timer_run;

    // Two-flop synchroniser plus one delay flop for rising-edge detection of all keys.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            key_s1 <= '0;
            key_s2 <= '0;
            key_d  <= '0;
        end else begin
            key_s1 <= {iStart, iHit};
            key_s2 <= key_s1;
            key_d  <= key_s2;
        end
    end

    assign key_rise   = key_s2 & ~key_d;
    assign start_rise = key_rise[4];
    assign hit_rise   = key_rise[3:0];

    // Free-running Fibonacci LFSR, taps 8,6,5,4; low two bits choose the next hole.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign mole_sel = state_t'({1'b0, lfsr[1:0]} + 3'd2);

    // Key mask of the hole whose mole is currently up (zero outside mole states).
    always_comb begin
        hole_mask = 4'b0000;
        case (state)
            ST_MOLE1: hole_mask = 4'b0001;
            ST_MOLE2: hole_mask = 4'b0010;
            ST_MOLE3: hole_mask = 4'b0100;
            ST_MOLE4: hole_mask = 4'b1000;
            default:  hole_mask = 4'b0000;
        endcase
    end

    assign in_mole      = |hole_mask;
    assign hit_correct  = in_mole && (|(hit_rise & hole_mask));
    assign hit_wrong    = in_mole && (|(hit_rise & ~hole_mask));
    assign mole_timeout = in_mole && (timer == MOLE_LAST);
    assign miss_upd     = (misses == 2'd3) ? 2'd3 : misses + 2'd1;
    assign round_end    = (32'(round) + 32'd1) == GAME_MOLES;
    assign miss_end     = 32'(miss_upd) == MAX_MISSES;

    // State register; the change flag marks the first cycle of every new state.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state     <= ST_START;
            state_chg <= 1'b0;
        end else begin
            state     <= state_nxt;
            state_chg <= (state_nxt != state);
        end
    end

    // Next-state: hit beats timeout beats wrong-hole miss.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_START: begin
                if (start_rise) state_nxt = ST_GAME;
            end
            ST_GAME: begin
                if (timer == GAP_LAST) state_nxt = mole_sel;
            end
            ST_MOLE1, ST_MOLE2, ST_MOLE3, ST_MOLE4: begin
                if (hit_correct) begin
                    state_nxt = round_end ? ST_OVER : ST_GAME;
                end else if (mole_timeout) begin
                    state_nxt = (round_end || miss_end) ? ST_OVER : ST_GAME;
                end else if (hit_wrong && miss_end) begin
                    state_nxt = ST_OVER;
                end
            end
            ST_OVER: begin
                if (start_rise) state_nxt = ST_START;
            end
            default: state_nxt = ST_START;
        endcase
    end

    // Counter and timer controls derived from the current state and key events.
    always_comb begin
        clr_cnt   = 1'b0;
        score_inc = 1'b0;
        miss_inc  = 1'b0;
        round_inc = 1'b0;
        timer_run = 1'b0;
        case (state)
            ST_START: clr_cnt = start_rise;
            ST_GAME:  timer_run = (state_nxt == state);
            ST_MOLE1, ST_MOLE2, ST_MOLE3, ST_MOLE4: begin
                score_inc = hit_correct;
                miss_inc  = !hit_correct && (mole_timeout || hit_wrong);
                round_inc = hit_correct || mole_timeout;
                timer_run = (state_nxt == state);
            end
            default: ;
        endcase
    end

    // Game counters and the shared gap/mole timer.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            score  <= '0;
            misses <= '0;
            round  <= '0;
            timer  <= '0;
        end else begin
            if (clr_cnt) begin
                score  <= '0;
                misses <= '0;
                round  <= '0;
            end else begin
                if (score_inc && (score != 8'hFF)) score <= score + 8'd1;
                if (miss_inc)                      misses <= miss_upd;
                if (round_inc)                     round  <= round + 5'd1;
            end
            timer <= timer_run ? timer + TIMER_W'(1) : '0;
        end
    end

    assign oState    = state;
    assign oStateChg = state_chg;
    assign oScore    = score;
    assign oMisses   = misses;
    assign oRound    = round;

endmodule
